// File: rtl/flash_boot_pkg.sv
// flash_boot_pkg: shared definitions for the SPI-flash boot loader.
//   - SPI flash command opcodes (read, reset-enable, reset)
//   - FSM state encoding used by flash_boot_loader
// The reset-sequence states only exist when FLASH_RESET_EN is defined.
package flash_boot_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_RST_EN = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;

  typedef enum logic [3:0] {
    ST_IDLE,
`ifdef FLASH_RESET_EN
    ST_RST1,
    ST_RST2,
    ST_RWAIT,
`endif
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode-0 bit engine for the flash boot loader.
//   SCK divider (toggles every CLK_DIV cycles while a transfer runs), internal
//   rise/fall strobes, MSB-first TX shift register and RX shift register.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   enable         engine may run; when low SCK is forced low and the divider cleared
//   load           start a transfer: latch tx_data (MSB-aligned) and nbits
//   nbits          number of SCK rises in the transfer (1..32)
//   tx_data        transmit word, bit 31 goes out first
//   miso           serial input, sampled on each rise strobe into the LSB
//   sck, mosi      flash clock and serial output (mosi valid before first rise)
//   rx_data        last RX_W received bits, first bit received in the MSB
//   xfer_done      1-cycle strobe on the fall that ends the last bit
module spi_shift_engine #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned RX_W    = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic [5:0]      nbits,
  input  logic [31:0]     tx_data,
  input  logic            miso,
  output logic            sck,
  output logic            mosi,
  output logic [RX_W-1:0] rx_data,
  output logic            xfer_done
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             running;
  logic [5:0]       bit_cnt;
  logic [31:0]      tx_sr;
  logic             tick;
  logic             rise;
  logic             fall;

  assign tick      = running && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise      = tick && !sck;
  assign fall      = tick && sck;
  // A transfer ends on the fall after its last rise so SCK always parks low.
  assign xfer_done = fall && (bit_cnt == '0);
  assign mosi      = tx_sr[31];

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      running <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_data <= '0;
      sck     <= 1'b0;
    end else if (load) begin
      div_cnt <= '0;
      running <= 1'b1;
      bit_cnt <= nbits;
      tx_sr   <= tx_data;
      sck     <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      running <= 1'b0;
      sck     <= 1'b0;
    end else if (running) begin
      if (tick) begin
        div_cnt <= '0;
        sck     <= !sck;
        if (rise) begin
          rx_data <= {rx_data[RX_W-2:0], miso};
          bit_cnt <= bit_cnt - 6'd1;
        end else begin
          tx_sr <= {tx_sr[30:0], 1'b0};
          if (bit_cnt == '0) running <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: streams WORD_COUNT big-endian words from SPI flash
// (read command 0x03 at FLASH_OFFSET) into a memory write port with
// valid/ready back-pressure and a start/busy/done handshake.
// Configuration macro: FLASH_RESET_EN -- when defined, every load first sends
//   0x66 and 0x99 frames and waits RESET_WAIT cycles before the read.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   start           1-cycle load request (ignored while busy)
//   busy, done      load in progress / sticky completion flag
//   spi_sck, spi_ssb, spi_mosi, spi_miso   SPI flash pins (mode 0)
//   mem_address, mem_data, mem_load, mem_ready   memory write port
module flash_boot_loader
  import flash_boot_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 8,
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter int unsigned WORD_BYTES   = 2,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned WORD_COUNT   = 16384,
  parameter int unsigned RESET_WAIT   = 400
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    spi_sck,
  output logic                    spi_ssb,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [8*WORD_BYTES-1:0] mem_data,
  output logic                    mem_load,
  input  logic                    mem_ready
);

  localparam int unsigned DW        = 8 * WORD_BYTES;
  localparam int unsigned CW        = $clog2(WORD_COUNT + 1);
  localparam logic [5:0]  DATA_BITS = 6'(DW);

  if (CLK_DIV < 2 || WORD_BYTES < 1 || WORD_BYTES > 4 || WORD_COUNT < 1 ||
      longint'(WORD_COUNT) > (longint'(1) << ADDR_WIDTH) || RESET_WAIT < 1) begin : g_bad_params
    $error("flash_boot_loader: illegal parameter combination");
  end

  state_t          state, state_d;
  logic            busy_d, done_d, ssb_d, load_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DW-1:0]   data_d;
  logic [CW-1:0]   wcnt, wcnt_d;

  logic            eng_en, eng_load, xfer_done;
  logic [5:0]      eng_nbits;
  logic [31:0]     eng_tx;
  logic [DW-1:0]   rx_data;

`ifdef FLASH_RESET_EN
  localparam int unsigned RW_W = $clog2(RESET_WAIT + 1);
  logic [RW_W-1:0] rwait, rwait_d;
`endif

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV),
    .RX_W    (DW)
  ) u_engine (
    .clock     (clock),
    .reset     (reset),
    .enable    (eng_en),
    .load      (eng_load),
    .nbits     (eng_nbits),
    .tx_data   (eng_tx),
    .miso      (spi_miso),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .rx_data   (rx_data),
    .xfer_done (xfer_done)
  );

  // A new transfer is loaded on the same edge that SSB falls (or the state
  // is entered), so the first MOSI bit is already valid when SSB goes low.
  always_comb begin
    state_d   = state;
    busy_d    = busy;
    done_d    = done;
    ssb_d     = spi_ssb;
    load_d    = mem_load;
    addr_d    = mem_address;
    data_d    = mem_data;
    wcnt_d    = wcnt;
    eng_en    = 1'b0;
    eng_load  = 1'b0;
    eng_nbits = 6'd8;
    eng_tx    = '0;
`ifdef FLASH_RESET_EN
    rwait_d   = rwait;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          done_d   = 1'b0;
          busy_d   = 1'b1;
          wcnt_d   = '0;
          addr_d   = '0;
          ssb_d    = 1'b0;
          eng_load = 1'b1;
`ifdef FLASH_RESET_EN
          eng_tx   = {CMD_RST_EN, 24'h0};
          state_d  = ST_RST1;
`else
          eng_tx   = {CMD_READ, 24'h0};
          state_d  = ST_CMD;
`endif
        end
      end
`ifdef FLASH_RESET_EN
      ST_RST1: begin
        eng_en = 1'b1;
        if (xfer_done) begin
          ssb_d   = 1'b1;
          state_d = ST_RST2;
        end
      end
      ST_RST2: begin
        eng_en = 1'b1;
        // First cycle here has SSB high from the 0x66 frame: that is the gap.
        if (spi_ssb) begin
          ssb_d    = 1'b0;
          eng_load = 1'b1;
          eng_tx   = {CMD_RST, 24'h0};
        end else if (xfer_done) begin
          ssb_d   = 1'b1;
          rwait_d = '0;
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (rwait == RW_W'(RESET_WAIT - 1)) begin
          ssb_d    = 1'b0;
          eng_load = 1'b1;
          eng_tx   = {CMD_READ, 24'h0};
          state_d  = ST_CMD;
        end else begin
          rwait_d = rwait + RW_W'(1);
        end
      end
`endif
      ST_CMD: begin
        eng_en = 1'b1;
        if (xfer_done) begin
          eng_load  = 1'b1;
          eng_nbits = 6'd24;
          eng_tx    = {FLASH_OFFSET, 8'h00};
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        eng_en = 1'b1;
        if (xfer_done) begin
          eng_load  = 1'b1;
          eng_nbits = DATA_BITS;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        eng_en = 1'b1;
        if (xfer_done) begin
          load_d  = 1'b1;
          data_d  = rx_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          load_d = 1'b0;
          if (wcnt == CW'(WORD_COUNT - 1)) begin
            state_d = ST_FINISH;
          end else begin
            addr_d    = mem_address + ADDR_WIDTH'(1);
            wcnt_d    = wcnt + CW'(1);
            eng_load  = 1'b1;
            eng_nbits = DATA_BITS;
            state_d   = ST_DATA;
          end
        end
      end
      ST_FINISH: begin
        ssb_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      spi_ssb     <= 1'b1;
      mem_load    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      wcnt        <= '0;
`ifdef FLASH_RESET_EN
      rwait       <= '0;
`endif
    end else begin
      state       <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      spi_ssb     <= ssb_d;
      mem_load    <= load_d;
      mem_address <= addr_d;
      mem_data    <= data_d;
      wcnt        <= wcnt_d;
`ifdef FLASH_RESET_EN
      rwait       <= rwait_d;
`endif
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: self-checking bench for flash_boot_loader with a
// behavioural SPI flash, a memory with controllable ready and a write scoreboard.
module tb_flash_boot_loader;

  localparam int unsigned CLK_DIV      = 2;
  localparam int unsigned WORD_BYTES   = 2;
  localparam int unsigned ADDR_WIDTH   = 14;
  localparam int unsigned WORD_COUNT   = 4;
  localparam int unsigned RESET_WAIT   = 400;
  localparam logic [23:0] FLASH_OFFSET = 24'h100000;
  localparam int unsigned DW           = 8 * WORD_BYTES;
  localparam int unsigned NBYTES       = WORD_BYTES * WORD_COUNT;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done, spi_sck, spi_ssb, spi_mosi, mem_load;
  logic spi_miso = 1'b0, mem_ready = 1'b0;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DW-1:0] mem_data;

  int unsigned vectors = 0, miscompares = 0;
  longint unsigned cycle = 0;

  flash_boot_loader #(
    .CLK_DIV      (CLK_DIV),
    .FLASH_OFFSET (FLASH_OFFSET),
    .WORD_BYTES   (WORD_BYTES),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .WORD_COUNT   (WORD_COUNT),
    .RESET_WAIT   (RESET_WAIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .spi_sck     (spi_sck),
    .spi_ssb     (spi_ssb),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_load    (mem_load),
    .mem_ready   (mem_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- flash model ----------------
  logic [7:0] img [NBYTES];

  typedef struct {
    logic [7:0]      cmd;
    int unsigned     bits;
    logic [23:0]     addr;
    longint unsigned t_start;
    longint unsigned t_end;
  } frame_t;
  frame_t frames[$];

  int unsigned     f_bits = 0, f_rd = 0;
  logic [31:0]     f_hdr = '0;
  longint unsigned fr_start = 0;

  function automatic logic flash_bit(input logic [23:0] a, input int unsigned idx);
    longint unsigned ba;
    logic [7:0] b;
    ba = longint'(a) + idx / 8;
    if (ba >= FLASH_OFFSET && ba < longint'(FLASH_OFFSET) + NBYTES) begin
      b = img[ba - FLASH_OFFSET];
      return b[7 - idx % 8];
    end
    return 1'b0;
  endfunction

  always @(negedge spi_ssb) begin
    f_bits = 0; f_rd = 0; f_hdr = '0; fr_start = cycle;
  end

  always @(posedge spi_sck) if (!spi_ssb) begin
    if (f_bits < 32) f_hdr = {f_hdr[30:0], spi_mosi};
    f_bits++;
  end

  // Mode 0: the flash shifts its next output bit on each falling SCK edge.
  always @(negedge spi_sck) if (!spi_ssb && f_bits >= 32 && f_hdr[31:24] == 8'h03) begin
    spi_miso = flash_bit(f_hdr[23:0], f_rd);
    f_rd++;
  end

  always @(posedge spi_ssb) if (f_bits != 0) begin
    frame_t f;
    f.cmd     = (f_bits >= 32) ? f_hdr[31:24] : f_hdr[7:0];
    f.bits    = f_bits;
    f.addr    = f_hdr[23:0];
    f.t_start = fr_start;
    f.t_end   = cycle;
    frames.push_back(f);
    f_bits = 0;
  end

  // ---------------- memory model ----------------
  int unsigned stall_len = 0, wait_cnt = 0;
  initial forever begin
    @(posedge clock); #1;
    if (mem_load) begin
      mem_ready = (wait_cnt >= stall_len);
      wait_cnt++;
    end else begin
      wait_cnt  = 0;
      mem_ready = (stall_len == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- scoreboard / monitors ----------------
  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         data;
  } wr_t;
  wr_t exp_q[$];

  logic                  prev_pending = 1'b0;
  logic [ADDR_WIDTH-1:0] prev_addr;
  logic [DW-1:0]         prev_data;
  int unsigned           hi_cnt = 0;

  always @(negedge clock) begin
    wr_t e;
    if (prev_pending) begin
      chk("stall_load_held", mem_load, 1'b1);
      chk("stall_addr_stable", mem_address, prev_addr);
      chk("stall_data_stable", mem_data, prev_data);
    end
    if (mem_load && !mem_ready) begin
      chk("stall_sck_low", spi_sck, 1'b0);
      chk("stall_ssb_low", spi_ssb, 1'b0);
    end
    prev_pending = mem_load && !mem_ready;
    prev_addr    = mem_address;
    prev_data    = mem_data;
    if (mem_load && mem_ready) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_address, mem_data);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", mem_address, e.addr);
        chk("write_data", mem_data, e.data);
      end
    end
    if (reset) hi_cnt = 0;
    else if (spi_sck) hi_cnt++;
    else if (hi_cnt != 0) begin
      chk("sck_high_cycles", hi_cnt, CLK_DIV);
      hi_cnt = 0;
    end
  end

  task automatic push_expect();
    wr_t w;
    exp_q.delete();
    for (int unsigned i = 0; i < WORD_COUNT; i++) begin
      w.addr = ADDR_WIDTH'(i);
      w.data = '0;
      for (int unsigned b = 0; b < WORD_BYTES; b++) w.data = (w.data << 8) | DW'(img[i * WORD_BYTES + b]);
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic check_frames();
    int unsigned rd;
`ifdef FLASH_RESET_EN
    chk("frame_count", frames.size(), 3);
    rd = 2;
    if (frames.size() == 3) begin
      chk("rst_en_cmd", frames[0].cmd, 8'h66);
      chk("rst_en_bits", frames[0].bits, 8);
      chk("rst_cmd", frames[1].cmd, 8'h99);
      chk("rst_bits", frames[1].bits, 8);
      chk("rst_gap_ok", (frames[2].t_start - frames[1].t_end) >= RESET_WAIT, 1'b1);
    end
`else
    chk("frame_count", frames.size(), 1);
    rd = 0;
`endif
    if (frames.size() > rd) begin
      chk("read_cmd", frames[rd].cmd, 8'h03);
      chk("read_addr", frames[rd].addr, FLASH_OFFSET);
      chk("read_bits", frames[rd].bits, 32 + WORD_COUNT * DW);
    end
  endtask

  task automatic run_load(input int unsigned stall, input bit poke_start);
    int unsigned n;
    stall_len = stall;
    push_expect();
    frames.delete();
    pulse_start();
    @(negedge clock);
    chk("busy_after_start", busy, 1'b1);
    chk("done_cleared", done, 1'b0);
    if (poke_start) begin
      repeat (100) @(posedge clock);
      pulse_start();
    end
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("load_finished", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("ssb_at_done", spi_ssb, 1'b1);
    chk("sck_at_done", spi_sck, 1'b0);
    chk("writes_missing", exp_q.size(), 0);
    check_frames();
  endtask

  task automatic randomize_image();
    for (int unsigned i = 0; i < NBYTES; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    int unsigned n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sck", spi_sck, 1'b0);
    chk("rst_ssb", spi_ssb, 1'b1);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_mem_load", mem_load, 1'b0);
    chk("rst_mem_address", mem_address, '0);
    chk("rst_mem_data", mem_data, '0);
    @(posedge clock); #1 reset = 1'b0;

    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(0, 1'b0);
    run_load(50, 1'b0);

    for (int k = 0; k < 3; k++) begin
      randomize_image();
      run_load($urandom_range(0, 6), k == 1);
    end

    // Abort during the data phase, then reload from scratch.
    randomize_image();
    stall_len = 0;
    push_expect();
    frames.delete();
    pulse_start();
    n = 0;
    while (f_bits < 40 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("reached_data_phase", f_bits >= 40, 1'b1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_ssb", spi_ssb, 1'b1);
    chk("abort_sck", spi_sck, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_mem_load", mem_load, 1'b0);
    exp_q.delete();
    repeat (5) @(posedge clock);
    randomize_image();
    run_load(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
